// File: rtl/seven_segment_scan_driver_if.sv
// rtl/seven_segment_scan_driver_if.sv - load bus and display outputs of the scan driver
interface seven_segment_scan_driver_if;
  logic [31:0] value;
  logic [7:0]  digit_en;
  logic [7:0]  dp_mask;
  logic        load;
  logic [3:0]  digit;
  logic [7:0]  anode;
  logic        dp;
  logic        frame_done;

  modport master (
    output value, digit_en, dp_mask, load,
    input  digit, anode, dp, frame_done
  );

  modport slave (
    input  value, digit_en, dp_mask, load,
    output digit, anode, dp, frame_done
  );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// rtl/seven_segment_scan_driver.sv - 8-digit multiplexed 7-segment scan driver, shadowed frame update
// Optional leading-zero blanking: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
module seven_segment_scan_driver #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic                         clk,
  input logic                         rst,
  seven_segment_scan_driver_if.slave  bus
);
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;
  localparam int CW = $clog2(PRESCALE + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - BLANK_CYCLES - 1);

  logic [0:0]    state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [2:0]    idx, nxt_idx;
  logic          wrap;
  logic [31:0]   act_value, sh_value, nxt_act_value;
  logic [7:0]    act_en, sh_en, nxt_act_en;
  logic [7:0]    act_dp, sh_dp, nxt_act_dp;
  logic          pending;
  logic [7:0]    lit;
  logic [7:0]    nxt_anode;
  logic          nxt_dp;
  logic [3:0]    nxt_digit;
  logic          nxt_frame_done;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
  logic [2:0]    msnz;
`endif

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 1'b1;
    nxt_idx   = idx;
    wrap      = 1'b0;
    if (state == ST_BLANK) begin
      if (cnt == BLANK_LAST) begin
        nxt_state = ST_SHOW;
        nxt_cnt   = '0;
      end
    end else if (cnt == SHOW_LAST) begin
      nxt_state = ST_BLANK;
      nxt_cnt   = '0;
      nxt_idx   = idx + 3'd1;
      wrap      = (idx == 3'd7);
    end

    // The shadow only reaches the display at a frame boundary.
    nxt_act_value = (wrap && pending) ? sh_value : act_value;
    nxt_act_en    = (wrap && pending) ? sh_en    : act_en;
    nxt_act_dp    = (wrap && pending) ? sh_dp    : act_dp;

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    msnz = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (nxt_act_value[4*i +: 4] != 4'd0) msnz = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      lit[i] = nxt_act_en[i] && (3'(i) <= msnz);
    end
`else
    lit = nxt_act_en;
`endif

    nxt_digit      = nxt_act_value[{nxt_idx, 2'b00} +: 4];
    nxt_anode      = 8'hFF;
    nxt_dp         = 1'b1;
    if (nxt_state == ST_SHOW && lit[nxt_idx]) begin
      nxt_anode[nxt_idx] = 1'b0;
      nxt_dp             = ~nxt_act_dp[nxt_idx];
    end
    nxt_frame_done = (nxt_state == ST_SHOW) && (nxt_idx == 3'd7) && (nxt_cnt == SHOW_LAST);
  end

  // Outputs are registered from the next-state view so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_BLANK;
      cnt            <= '0;
      idx            <= 3'd0;
      act_value      <= 32'd0;
      act_en         <= 8'h01;
      act_dp         <= 8'h00;
      sh_value       <= 32'd0;
      sh_en          <= 8'h00;
      sh_dp          <= 8'h00;
      pending        <= 1'b0;
      bus.anode      <= 8'hFF;
      bus.dp         <= 1'b1;
      bus.digit      <= 4'd0;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= nxt_state;
      cnt            <= nxt_cnt;
      idx            <= nxt_idx;
      act_value      <= nxt_act_value;
      act_en         <= nxt_act_en;
      act_dp         <= nxt_act_dp;
      if (bus.load) begin
        sh_value <= bus.value;
        sh_en    <= bus.digit_en;
        sh_dp    <= bus.dp_mask;
        pending  <= 1'b1;
      end else if (wrap) begin
        pending  <= 1'b0;
      end
      bus.anode      <= nxt_anode;
      bus.dp         <= nxt_dp;
      bus.digit      <= nxt_digit;
      bus.frame_done <= nxt_frame_done;
    end
  end
endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// tb/tb_seven_segment_scan_driver.sv - self-checking bench for seven_segment_scan_driver
module tb_seven_segment_scan_driver;
  localparam int PS = 8;
  localparam int BC = 2;
  localparam int FRAME = 8 * PS;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  seven_segment_scan_driver_if bus ();

  seven_segment_scan_driver #(.PRESCALE(PS), .BLANK_CYCLES(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: time since reset decides slot/phase; the active set changes only at frame starts.
  int          t;
  logic [31:0] m_av, m_sv;
  logic [7:0]  m_ae, m_se, m_ad, m_sd;
  bit          m_pend;

  typedef struct {
    logic [31:0] value;
    logic [7:0]  en;
    logic [7:0]  dpm;
    int          slot;
    logic [3:0]  e_digit;
    logic [7:0]  e_anode;
    logic        e_dp;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  function automatic bit m_lit(input int s);
    int top;
    top = 0;
    for (int i = 7; i >= 1; i--) if (top == 0 && m_av[4*i +: 4] != 4'd0) top = i;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    return m_ae[s] && (s <= top);
`else
    return m_ae[s] && (top >= 0);
`endif
  endfunction

  task automatic check_outputs();
    int  slot, pos;
    bit  on;
    logic [7:0] ea;
    slot = (t / PS) % 8;
    pos  = t % PS;
    on   = (pos >= BC) && m_lit(slot);
    ea   = on ? ~(8'h01 << slot) : 8'hFF;
    chk("anode", {24'd0, bus.anode}, {24'd0, ea});
    chk("dp", {31'd0, bus.dp}, {31'd0, !(on && m_ad[slot])});
    chk("digit", {28'd0, bus.digit}, {28'd0, m_av[4*slot +: 4]});
    chk("frame_done", {31'd0, bus.frame_done}, {31'd0, (t % FRAME) == FRAME - 1});
  endtask

  task automatic tick();
    if (rst) begin
      t = 0; m_av = 0; m_ae = 8'h01; m_ad = 0; m_sv = 0; m_se = 0; m_sd = 0; m_pend = 0;
    end else begin
      t++;
      if (t % FRAME == 0 && m_pend) begin
        m_av = m_sv; m_ae = m_se; m_ad = m_sd; m_pend = 0;
      end
      if (bus.load) begin
        m_sv = bus.value; m_se = bus.digit_en; m_sd = bus.dp_mask; m_pend = 1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dpm);
    bus.value = v; bus.digit_en = en; bus.dp_mask = dpm; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic advance_to(input int pos);
    for (int k = 0; k < 2 * FRAME && (t % FRAME) != pos; k++) tick();
  endtask

  task automatic next_frame();
    tick();
    advance_to(0);
  endtask

  initial begin
    vecs[0] = '{32'h76543210, 8'hFF, 8'h04, 2, 4'd2, 8'hFB, 1'b0};
    vecs[1] = '{32'h76543210, 8'hFF, 8'h04, 5, 4'd5, 8'hDF, 1'b1};
    vecs[2] = '{32'h76543210, 8'h05, 8'h00, 1, 4'd1, 8'hFF, 1'b1};
    vecs[3] = '{32'h76543210, 8'h05, 8'h00, 2, 4'd2, 8'hFB, 1'b1};
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    vecs[4] = '{32'h00000120, 8'hFF, 8'h00, 4, 4'd0, 8'hFF, 1'b1};
`else
    vecs[4] = '{32'h00000120, 8'hFF, 8'h00, 4, 4'd0, 8'hEF, 1'b1};
`endif
    vecs[5] = '{32'h89ABCDEF, 8'h80, 8'h80, 7, 4'd8, 8'h7F, 1'b0};

    t = 0;
    rst = 1'b1;
    bus.value = 32'd0; bus.digit_en = 8'd0; bus.dp_mask = 8'd0; bus.load = 1'b0;
    tick();
    tick();
    chk("reset_anode", {24'd0, bus.anode}, 32'hFF);
    chk("reset_digit", {28'd0, bus.digit}, 32'h0);
    chk("reset_frame_done", {31'd0, bus.frame_done}, 32'h0);
    rst = 1'b0;

    // Idle frames: 2 blank cycles then digit 0 on anode FE, frame_done once per 64 cycles.
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
        tick();
        if (t == 1) chk("idle_blank", {24'd0, bus.anode}, 32'hFF);
        if (t == 2) chk("idle_show", {24'd0, bus.anode}, 32'hFE);
        if (bus.frame_done) pulses++;
      end
      chk("idle_pulses", pulses, 2);
    end

    // Table vectors: load mid-frame, check one slot of the following frame.
    foreach (vecs[i]) begin
      advance_to(20);
      do_load(vecs[i].value, vecs[i].en, vecs[i].dpm);
      next_frame();
      advance_to(vecs[i].slot * PS + 4);
      chk($sformatf("vec%0d_digit", i), {28'd0, bus.digit}, {28'd0, vecs[i].e_digit});
      chk($sformatf("vec%0d_anode", i), {24'd0, bus.anode}, {24'd0, vecs[i].e_anode});
      chk($sformatf("vec%0d_dp", i), {31'd0, bus.dp}, {31'd0, vecs[i].e_dp});
    end

    // Two loads in one frame: the later one wins.
    advance_to(10);
    do_load(32'h11111111, 8'hFF, 8'h00);
    advance_to(30);
    do_load(32'h22222222, 8'hFF, 8'h00);
    next_frame();
    advance_to(3 * PS + 4);
    chk("last_load_wins_s3", {28'd0, bus.digit}, 32'h2);
    advance_to(6 * PS + 4);
    chk("last_load_wins_s6", {28'd0, bus.digit}, 32'h2);

    // Load on the wrap cycle lands one frame later.
    advance_to(FRAME - 1);
    do_load(32'h33333333, 8'hFF, 8'h00);
    advance_to(4);
    chk("wrap_load_old", {28'd0, bus.digit}, 32'h2);
    next_frame();
    advance_to(4);
    chk("wrap_load_new", {28'd0, bus.digit}, 32'h3);

    // Reset in the SHOW phase of slot 5, with a load that must be ignored.
    advance_to(5 * PS + 4);
    rst = 1'b1;
    bus.value = 32'hFFFFFFFF; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    rst = 1'b0;
    chk("midreset_anode", {24'd0, bus.anode}, 32'hFF);
    chk("midreset_digit", {28'd0, bus.digit}, 32'h0);
    tick(); tick();
    chk("midreset_slot0", {24'd0, bus.anode}, 32'hFE);
    next_frame();
    advance_to(4);
    chk("midreset_load_ignored", {28'd0, bus.digit}, 32'h0);

    // Randomised loads and occasional resets against the reference.
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      bus.value    = $urandom;
      bus.digit_en = 8'($urandom);
      bus.dp_mask  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) bus.value[31:16] = 16'd0;
      bus.load     = ($urandom_range(0, 15) == 0);
      tick();
    end
    rst = 1'b0;
    bus.load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
